// File: rtl/test_sequencer.sv
// Test-control block: holds the DUT in reset, runs it until halt or timeout, then streams
// the register file out over valid/ready. Define TEST_SEQ_SIGNATURE_EN to add the dump signature.
module test_sequencer #(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 32,
    localparam int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              dut_rst,
    input  logic              halt_i,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]   rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [XLEN-1:0]   dump_data,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              timeout,
    output logic              done,
    output logic [XLEN-1:0]   signature
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int RIDX_W = ADDR_W + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [RIDX_W-1:0] RIDX_END  = RIDX_W'(NUM_REGS);
    localparam bit                TO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [RIDX_W-1:0] ridx_r;
    logic              dut_rst_r;
    logic              dump_valid_r;
    logic [ADDR_W-1:0] dump_idx_r;
    logic [XLEN-1:0]   dump_data_r;
    logic [CNT_W-1:0]  cycle_count_r;
    logic              timeout_r;
    logic              done_r;
    logic              fire_s;
    logic              load_s;
    logic              last_fire_s;
    logic              timeout_hit_s;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_HOLD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-cycle strobes; halt wins over a same-cycle timeout
    always_comb begin
        state_s       = state_r;
        fire_s        = 1'b0;
        load_s        = 1'b0;
        last_fire_s   = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (halt_i) begin
                    state_s = ST_DUMP;
                end else if (TO_EN && (cycle_count_r == TO_LAST)) begin
                    state_s       = ST_DUMP;
                    timeout_hit_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DUMP: begin
                fire_s      = dump_valid_r && dump_ready;
                load_s      = (!dump_valid_r || dump_ready) && (ridx_r < RIDX_END);
                last_fire_s = fire_s && (dump_idx_r == LAST_IDX);
                if (last_fire_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DUMP;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_HOLD;
            end
        endcase
    end

    // Reset-hold counter and DUT reset output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
            dut_rst_r  <= 1'b1;
        end else begin
            if ((state_r == ST_HOLD) && (state_s == ST_HOLD)) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end
            dut_rst_r <= (state_s == ST_HOLD);
        end
    end

    // Run-cycle counter; it stops on the exit cycle so it reads the last RUN cycle index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count_r <= {CNT_W{1'b0}};
            timeout_r     <= 1'b0;
        end else begin
            if ((state_r == ST_RUN) && (state_s == ST_RUN) && (cycle_count_r != CNT_MAX)) begin
                cycle_count_r <= cycle_count_r + CNT_W'(1);
            end
            if (timeout_hit_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    // Dump output stage: one skid-free register refilled whenever it is empty or draining
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ridx_r       <= {RIDX_W{1'b0}};
            dump_valid_r <= 1'b0;
            dump_idx_r   <= {ADDR_W{1'b0}};
            dump_data_r  <= {XLEN{1'b0}};
        end else if (load_s) begin
            dump_valid_r <= 1'b1;
            dump_idx_r   <= ridx_r[ADDR_W-1:0];
            dump_data_r  <= rf_rdata;
            ridx_r       <= ridx_r + RIDX_W'(1);
        end else if (fire_s) begin
            dump_valid_r <= 1'b0;
        end
    end

    // Sticky completion flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_r <= 1'b0;
        end else if (last_fire_s) begin
            done_r <= 1'b1;
        end
    end

`ifdef TEST_SEQ_SIGNATURE_EN
    logic [XLEN-1:0] signature_r;

    function automatic logic [XLEN-1:0] sig_next(input logic [XLEN-1:0] sig,
                                                 input logic [XLEN-1:0] data);
        return {sig[XLEN-2:0], sig[XLEN-1]} ^ data;
    endfunction

    // Rotate-xor signature over every accepted beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signature_r <= {XLEN{1'b0}};
        end else if (fire_s) begin
            signature_r <= sig_next(signature_r, dump_data_r);
        end
    end

    assign signature = signature_r;
`else
    assign signature = {XLEN{1'b0}};
`endif

    assign dut_rst     = dut_rst_r;
    assign rf_raddr    = ridx_r[ADDR_W-1:0];
    assign dump_valid  = dump_valid_r;
    assign dump_idx    = dump_idx_r;
    assign dump_data   = dump_data_r;
    assign cycle_count = cycle_count_r;
    assign timeout     = timeout_r;
    assign done        = done_r;

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: stimulus pushes expected dump beats, a negedge monitor
// pops and compares each accepted beat and checks stability while stalled.
module tb_test_sequencer;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = 5;
    localparam int RST_CYCLES = 4;
    localparam int TIMEOUT    = 100;
    localparam int CNT_W      = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              halt_i = 1'b0;
    logic              dump_ready = 1'b0;
    logic              dut_rst;
    logic              dump_valid;
    logic              timeout;
    logic              done;
    logic [ADDR_W-1:0] rf_raddr;
    logic [ADDR_W-1:0] dump_idx;
    logic [XLEN-1:0]   rf_rdata;
    logic [XLEN-1:0]   dump_data;
    logic [XLEN-1:0]   signature;
    logic [CNT_W-1:0]  cycle_count;

    logic [XLEN-1:0]          rf_mem [NUM_REGS];
    logic [ADDR_W+XLEN-1:0]   sb_q [$];
    int                       n_cmp = 0;
    int                       n_err = 0;
    bit                       stall_prev = 1'b0;
    logic [ADDR_W-1:0]        prev_idx;
    logic [XLEN-1:0]          prev_data;
    bit                       bp_en = 1'b0;
    int                       bp_phase = 0;
    logic [3:0]               bp_pat = 4'b1001;

    test_sequencer #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .RST_CYCLES(RST_CYCLES),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .dut_rst(dut_rst), .halt_i(halt_i),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data),
        .cycle_count(cycle_count), .timeout(timeout), .done(done),
        .signature(signature)
    );

    assign rf_rdata = rf_mem[rf_raddr];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each accepted beat against the scoreboard; stalled beats must hold
    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else if (dump_valid) begin
            if (stall_prev) begin
                check("stall_idx", dump_idx, prev_idx);
                check("stall_data", dump_data, prev_data);
            end
            if (dump_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat_unexpected: got idx %0d, expected no beat", dump_idx);
                end else begin
                    logic [ADDR_W+XLEN-1:0] e;
                    e = sb_q.pop_front();
                    check("beat_idx", dump_idx, e[ADDR_W+XLEN-1:XLEN]);
                    check("beat_data", dump_data, e[XLEN-1:0]);
                end
                if (bp_en && dump_idx == 5'd5) check("bp_idx5_data", dump_data, 32'h5555_5555);
            end
            stall_prev = !dump_ready;
            prev_idx   = dump_idx;
            prev_data  = dump_data;
        end else begin
            if (stall_prev) check("valid_dropped", 1'b0, 1'b1);
            stall_prev = 1'b0;
        end
    end

    // Backpressure driver: ready follows 1,0,0,1 repeating
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            dump_ready = bp_pat[bp_phase % 4];
            bp_phase++;
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, dump_valid, 1'b0);
        check({tag, "_idx"}, dump_idx, '0);
        check({tag, "_data"}, dump_data, '0);
        check({tag, "_cnt"}, cycle_count, '0);
        check({tag, "_timeout"}, timeout, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_sig"}, signature, '0);
        check({tag, "_raddr"}, rf_raddr, '0);
    endtask

    task automatic apply_reset();
        #1 rst = 1'b0;
        sb_q.delete();
        halt_i = 1'b0;
        dump_ready = 1'b0;
        bp_en = 1'b0;
        bp_phase = 0;
        #1;
        check("rst_dut_rst", dut_rst, 1'b1);
        check_quiet("rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Ends on the negedge of RUN cycle 0
    task automatic check_hold();
        for (int k = 0; k < RST_CYCLES; k++) begin
            @(negedge clk);
            check("hold_dut_rst", dut_rst, 1'b1);
            check_quiet("hold");
        end
        @(negedge clk);
        check("run_dut_rst", dut_rst, 1'b0);
        check("run_cnt0", cycle_count, '0);
    endtask

    task automatic push_all();
        for (int i = 0; i < NUM_REGS; i++) sb_q.push_back({i[ADDR_W-1:0], rf_mem[i]});
    endtask

    task automatic wait_done(input int bound);
        for (int k = 0; k < bound && !done; k++) @(posedge clk);
        #1;
        check("done_reached", done, 1'b1);
        check("done_valid_low", dump_valid, 1'b0);
        check("sb_empty", sb_q.size(), 0);
    endtask

    function automatic logic [XLEN-1:0] sig_expected();
        logic [XLEN-1:0] s;
        s = '0;
`ifdef TEST_SEQ_SIGNATURE_EN
        for (int i = 0; i < NUM_REGS; i++) s = {s[XLEN-2:0], s[XLEN-1]} ^ rf_mem[i];
`endif
        return s;
    endfunction

    // Halt at RUN cycle h with ready held high: exact latency and one beat per cycle
    task automatic run_halt_full(input int h);
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = 32'hC0DE_0000 + i;
        check_hold();
        push_all();
        dump_ready = 1'b1;
        repeat (h) @(negedge clk);
        halt_i = 1'b1;
        @(posedge clk);
        #1 halt_i = 1'b0;
        check("halt_cnt", cycle_count, h);
        check("halt_timeout", timeout, 1'b0);
        check("halt_entry_valid", dump_valid, 1'b0);
        @(posedge clk);
        #1;
        check("first_valid", dump_valid, 1'b1);
        check("first_idx", dump_idx, '0);
        repeat (31) @(posedge clk);
        #1;
        check("last_idx", dump_idx, 5'd31);
        check("last_done_low", done, 1'b0);
        @(posedge clk);
        #1;
        check("full_done", done, 1'b1);
        check("full_valid", dump_valid, 1'b0);
        check("full_sb_empty", sb_q.size(), 0);
        check("full_sig", signature, sig_expected());
        halt_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 halt_i = 1'b0;
        check("done_hold", done, 1'b1);
        check("done_cnt_hold", cycle_count, h);
        check("done_dut_rst", dut_rst, 1'b0);
        check("done_valid_hold", dump_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Halt path at RUN cycle 15
        @(posedge clk);
        apply_reset();
        run_halt_full(15);

        // Timeout path with 1,0,0,1 backpressure
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = i * 32'h1111_1111;
        apply_reset();
        check_hold();
        push_all();
        repeat (99) @(negedge clk);
        check("to_cnt99", cycle_count, 32'd99);
        check("to_pre", timeout, 1'b0);
        @(posedge clk);
        #1;
        check("to_flag", timeout, 1'b1);
        check("to_cnt_frozen", cycle_count, 32'd99);
        bp_en = 1'b1;
        wait_done(300);
        bp_en = 1'b0;
        check("to_flag_sticky", timeout, 1'b1);

        // Halt coinciding with timeout, single-bit register file for the signature
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
        rf_mem[1] = 32'h0000_0001;
        apply_reset();
        check_hold();
        push_all();
        dump_ready = 1'b1;
        repeat (99) @(negedge clk);
        halt_i = 1'b1;
        @(posedge clk);
        #1 halt_i = 1'b0;
        check("tie_timeout", timeout, 1'b0);
        check("tie_cnt", cycle_count, 32'd99);
        wait_done(100);
`ifdef TEST_SEQ_SIGNATURE_EN
        check("sig_value", signature, 32'h4000_0000);
`else
        check("sig_value", signature, 32'h0000_0000);
`endif

        // Reset during beat idx 10, then a clean rerun
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = 32'hC0DE_0000 + i;
        apply_reset();
        check_hold();
        push_all();
        dump_ready = 1'b1;
        repeat (3) @(negedge clk);
        halt_i = 1'b1;
        @(posedge clk);
        #1 halt_i = 1'b0;
        begin
            int k;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!(dump_valid && dump_idx == 5'd10) && k < 60);
            check("mid_reached_idx10", dump_idx, 5'd10);
        end
        apply_reset();
        run_halt_full(15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
